// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access stage of the five-stage MIPS pipeline. It registers the
//   EX-to-MEM bus, waits on a variable-latency data-SRAM read response
//   (stalling the pipeline until it arrives), aligns and extends load data,
//   and drives the MEM-to-WB and MEM-to-ID (forwarding) buses.
//
// Ports
//   clk               : rising-edge clock
//   resetn            : asynchronous active-low reset
//   stall             : pipeline stall vector, bit 3 = this stage, bit 4 = WB
//                       (1 = Stop, 0 = NoStop)
//   ex_to_mem_bus     : {pc, data_ram_en, data_ram_wen, mem_op, sel_rf_res,
//                        rf_we, rf_waddr, ex_result}
//   data_sram_rdata   : read data, meaningful only with data_sram_rvalid
//   data_sram_rvalid  : one-cycle response pulse per issued load
//   mem_to_wb_bus     : {pc, rf_we, rf_waddr, rf_wdata}
//   mem_to_id_bus     : {rf_we, rf_waddr, rf_wdata}
//   stallreq_for_mem  : stall request while a load response is outstanding
//
// Handshake: the SRAM response is a bare valid pulse with no ready. A load
// in bus_q is pending until the first rvalid seen in IDLE or WAIT; that
// pulse completes it. In DONE the captured word is reused and rvalid is
// ignored until the stage register moves on.
// -----------------------------------------------------------------------------
module mem_stage #(
   parameter int EX_TO_MEM_WD = 79,
   parameter int MEM_TO_WB_WD = 70,
   parameter int MEM_TO_ID_WD = 38,
   parameter int StallBus     = 6
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [StallBus-1:0]     stall,
   input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   input  logic [31:0]             data_sram_rdata,
   input  logic                    data_sram_rvalid,
   output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
   output logic                    stallreq_for_mem
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [EX_TO_MEM_WD-1:0] bus_q, bus_d;
   logic [31:0]             rdata_q, rdata_d;

   // Only bits 3 and 4 of the stall vector concern this stage.
   logic unused_stall;
   assign unused_stall = ^{stall[StallBus-1:5], stall[2:0]};

   // Stage register fields
   logic [31:0] mem_pc;
   logic        data_ram_en;
   logic [3:0]  data_ram_wen;
   logic [2:0]  mem_op;
   logic        sel_rf_res;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] ex_result;

   assign mem_pc       = bus_q[78:47];
   assign data_ram_en  = bus_q[46];
   assign data_ram_wen = bus_q[45:42];
   assign mem_op       = bus_q[41:39];
   assign sel_rf_res   = bus_q[38];
   assign rf_we        = bus_q[37];
   assign rf_waddr     = bus_q[36:32];
   assign ex_result    = bus_q[31:0];

   logic bubble;
   logic load_en;
   logic advance;
   logic is_load;
   logic pending;

   assign bubble  = stall[3] & ~stall[4];
   assign load_en = ~stall[3];
   assign advance = bubble | load_en;
   assign is_load = data_ram_en & (data_ram_wen == 4'b0000);
   // A load still waiting for (or receiving) its response this cycle.
   assign pending = is_load & (state_q != ST_DONE);

   assign stallreq_for_mem = pending & ~data_sram_rvalid;

   always_comb begin
      bus_d = bus_q;
      if (bubble) begin
         bus_d = '0;
      end else if (load_en) begin
         bus_d = ex_to_mem_bus;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (pending && data_sram_rvalid) begin
         rdata_d = data_sram_rdata;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_WAIT: begin
            if (is_load) begin
               state_d = data_sram_rvalid ? ST_DONE : ST_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DONE: state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
      // Whatever enters bus_q on this edge is a new instruction and must be
      // evaluated fresh, so a stage-register update always wins.
      if (advance) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         bus_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         bus_q   <= bus_d;
         rdata_q <= rdata_d;
      end
   end

   // Load alignment: the live response is used in the completing cycle,
   // the captured word for every cycle after that.
   logic [31:0] load_raw;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_data;

   assign load_raw = (state_q == ST_DONE) ? rdata_q : data_sram_rdata;

   always_comb begin
      case (ex_result[1:0])
         2'd0:    load_byte = load_raw[7:0];
         2'd1:    load_byte = load_raw[15:8];
         2'd2:    load_byte = load_raw[23:16];
         default: load_byte = load_raw[31:24];
      endcase
      load_half = ex_result[1] ? load_raw[31:16] : load_raw[15:0];
   end

   always_comb begin
      case (mem_op)
         3'd1:    load_data = {{24{load_byte[7]}}, load_byte};
         3'd2:    load_data = {24'b0, load_byte};
         3'd3:    load_data = {{16{load_half[15]}}, load_half};
         3'd4:    load_data = {16'b0, load_half};
         default: load_data = load_raw;
      endcase
   end

   logic [31:0] rf_wdata;
   logic        rf_we_out;

   assign rf_wdata  = sel_rf_res ? load_data : ex_result;
   assign rf_we_out = rf_we & ~stallreq_for_mem;

   assign mem_to_wb_bus = {mem_pc, rf_we_out, rf_waddr, rf_wdata};
   assign mem_to_id_bus = {rf_we_out, rf_waddr, rf_wdata};

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, directly downstream of EX. It registers the EX-to-MEM bus and waits on a variable-latency data-SRAM read response, stalling the pipeline until the response arrives. It aligns and extends load data, then drives the MEM-to-WB bus and the MEM-to-ID forwarding bus.

## Interface
Parameters:
- `EX_TO_MEM_WD`, 79: input bus width. Packing, MSB first: `ex_pc[78:47]`, `data_ram_en[46]`, `data_ram_wen[45:42]`, `mem_op[41:39]`, `sel_rf_res[38]`, `rf_we[37]`, `rf_waddr[36:32]`, `ex_result[31:0]`.
- `MEM_TO_WB_WD`, 70: `{mem_pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}`.
- `MEM_TO_ID_WD`, 38: `{rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `resetn`, input, 1: asynchronous, active-low reset.
- `stall`, input, `StallBus`: pipeline stall vector; bit 3 = this stage, bit 4 = WB.
- `ex_to_mem_bus`, input, `EX_TO_MEM_WD`: from EX.
- `data_sram_rdata`, input, 32: read data, valid only when `data_sram_rvalid` = 1.
- `data_sram_rvalid`, input, 1: one-cycle pulse per issued load.
- `mem_to_wb_bus`, output, `MEM_TO_WB_WD`: to WB.
- `mem_to_id_bus`, output, `MEM_TO_ID_WD`: forwarding bus to ID.
- `stallreq_for_mem`, output, 1: request to the stall controller.

## Operation
- **Stage register `bus_r`:**
  - If `stall[3]`=Stop and `stall[4]`=NoStop, clear to 0 (bubble).
  - Else if `stall[3]`=NoStop, load `ex_to_mem_bus`.
  - Otherwise hold.
- **Load detection:** `is_load` = `data_ram_en` & (`data_ram_wen` == 0). Stores and ALU operations never stall.
- **FSM states:**
  - **IDLE:**
    - `is_load` & !`rvalid`: assert `stallreq_for_mem`, go to WAIT.
    - `is_load` & `rvalid`: capture `rdata` into `rdata_r`, go to DONE. Data is used combinationally this cycle; no stall.
  - **WAIT:**
    - `stallreq_for_mem` = 1 until `rvalid`.
    - On `rvalid`: capture into `rdata_r`, deassert stall in the same cycle using the live `rdata`, go to DONE.
  - **DONE:**
    - Load data comes from `rdata_r`; `rvalid` is ignored.
    - Return to IDLE on any cycle where `bus_r` loads or clears (`stall[3]`=NoStop, or the bubble condition).
- `rvalid` in IDLE with no load present is ignored.
- **Alignment** (little-endian; `off` = `ex_result[1:0]`):
  - `mem_op` 0 = `lw`: word.
  - `mem_op` 1 = `lb`: byte at `off`, sign-extended.
  - `mem_op` 2 = `lbu`: byte at `off`, zero-extended.
  - `mem_op` 3 = `lh`: half at `off[1]`, sign-extended.
  - `mem_op` 4 = `lhu`: half at `off[1]`, zero-extended.
  - `mem_op` 5–7: treated as `lw`.
  - `off[0]` is ignored for halfwords.
- **Write data:** `rf_wdata` = `sel_rf_res` ? aligned load data : `ex_result`.
- **Write-enable gating:** `rf_we` on both output buses is forced to 0 while `stallreq_for_mem` = 1.

## Timing
- **Reset:** while `resetn` = 0, asynchronously:
  - `bus_r` = 0, `rdata_r` = 0, FSM = IDLE.
  - All outputs 0, including `stallreq_for_mem`.
- Reset deassertion during WAIT abandons the load. No response is expected afterwards; a late `rvalid` is ignored.
- **Latency:**
  - Non-load: 0 cycles added; outputs are combinational from `bus_r`.
  - Load with `rvalid` in the first cycle: 0 stall cycles.
  - Load with response N cycles after entry: exactly N stall cycles.
- `stallreq_for_mem` is combinational from FSM state, `is_load` and `rvalid`. It never asserts in DONE.
- **Held after completion:** if a WB stall holds `bus_r` after the load completes, outputs stay stable from `rdata_r` for every held cycle.
- **Simultaneous events:** a new instruction latched in the same edge as DONE→IDLE is evaluated fresh in IDLE on the next cycle.

## Test plan
- **Word load, immediate response:** `lw`, `ex_result`=0x100, `rvalid` in the entry cycle with `rdata`=0xDEADBEEF → no stall; WB bus `rf_we`=1, `wdata`=0xDEADBEEF.
- **Delayed response:** `lw` with `rvalid` 3 cycles late → `stallreq_for_mem`=1 for exactly 3 cycles and WB `rf_we`=0 during them; on the 4th cycle `wdata`=`rdata`.
- **Byte/half extension:** `rdata`=0x80FF7F01:
  - `lb` off=3 → 0xFFFFFF80.
  - `lbu` off=3 → 0x00000080.
  - `lh` off=2 → 0xFFFF80FF.
  - `lhu` off=0 → 0x00007F01.
- **Held after completion:** load completes, then `stall[3]`=`stall[4]`=Stop for 2 cycles → `wdata` held from `rdata_r`, no stall, `rvalid` ignored.
- **Bubble and ALU pass-through:** `stall[3]`=Stop, `stall[4]`=NoStop → next cycle both buses 0. ALU op with `ex_result`=0x1234, `sel_rf_res`=0 → `wdata`=0x1234, no stall.
- **Reset mid-load:** assert `resetn`=0 in WAIT → all outputs 0 immediately. A late `rvalid` after release → no effect.
